// File: rtl/video_stream_gen_pkg.sv
// Shared pattern codes, FSM encoding and geometry width for the video stream generator.
// Optional ready back-pressure lives behind VIDEO_STREAM_GEN_READY_EN (see the interface and top).
package video_stream_pkg;

  localparam int DIM_WIDTH_DEF = 16;

  localparam logic [1:0] PAT_XRAMP = 2'd0;
  localparam logic [1:0] PAT_YRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } vs_state_t;

endpackage

// File: rtl/video_stream_gen_if.sv
// Pixel-stream interface: data/de/hs/vs, with hs and vs only ever asserted together with de.
// With VIDEO_STREAM_GEN_READY_EN defined, the sink may stall a pixel slot by holding rdy low.
interface video_stream_gen_if #(
    parameter int PIXEL_WIDTH = 12
);
    logic [PIXEL_WIDTH-1:0] data;
    logic                   de;
    logic                   hs;
    logic                   vs;
`ifdef VIDEO_STREAM_GEN_READY_EN
    logic                   rdy;

    modport master (output data, de, hs, vs, input rdy);
    modport slave  (input data, de, hs, vs, output rdy);
`else
    modport master (output data, de, hs, vs);
    modport slave  (input data, de, hs, vs);
`endif
endinterface

// File: rtl/video_stream_pattern.sv
// Combinational test-pattern source: maps a pixel position and pattern select to a pixel value.
// Also used by the overlay block, so it carries no state.
module video_stream_pattern
  import video_stream_pkg::*;
#(
    parameter int PIXEL_WIDTH = 12,
    parameter int DIM_WIDTH   = DIM_WIDTH_DEF
) (
    input  logic [DIM_WIDTH-1:0]   x,
    input  logic [DIM_WIDTH-1:0]   y,
    input  logic [1:0]             sel,
    input  logic [PIXEL_WIDTH-1:0] val,
    output logic [PIXEL_WIDTH-1:0] pix
);

    always_comb begin
        pix = '0;
        case (sel)
            PAT_XRAMP: pix = PIXEL_WIDTH'(x);
            PAT_YRAMP: pix = PIXEL_WIDTH'(y);
            PAT_CHECK: pix = (x[3] ^ y[3]) ? '1 : '0;
            default:   pix = val;
        endcase
    end

endmodule

// File: rtl/video_stream_gen.sv
// Frame generator for the pixel-stream interface: programmable geometry, sparse pixel pacing.
// Defining VIDEO_STREAM_GEN_READY_EN adds rdy back-pressure; otherwise the stream free-runs.
module video_stream_gen
  import video_stream_pkg::*;
#(
    parameter int PIXEL_WIDTH = 12,
    parameter int SPARSE      = 2,
    parameter int DIM_WIDTH   = DIM_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [DIM_WIDTH-1:0]   line_size,
    input  logic [DIM_WIDTH-1:0]   line_count,
    input  logic [DIM_WIDTH-1:0]   hblank,
    input  logic [DIM_WIDTH-1:0]   vblank,
    input  logic [1:0]             pattern_sel,
    input  logic [PIXEL_WIDTH-1:0] pattern_val,
    video_stream_gen_if.master     vid,
    output logic                   frame_done_o,
    output vs_state_t              state_o
);

    localparam int SW = (SPARSE < 1) ? 1 : $clog2(SPARSE + 1);
    localparam logic [SW-1:0] SPARSE_LD = SW'(SPARSE);

    vs_state_t              st;
    logic [DIM_WIDTH-1:0]   x, y, blank_cnt;
    logic [SW-1:0]          sparse_cnt;
    logic                   eol_pend;
    logic [DIM_WIDTH-1:0]   ls_s, lc_s, hb_s, vb_s;
    logic [1:0]             sel_s;
    logic [PIXEL_WIDTH-1:0] val_s;
    logic [PIXEL_WIDTH-1:0] data_r, pix;
    logic                   de_r, hs_r, vs_r, fd_r;

    logic start_ok, last_x, last_y, hb_last, vb_last;
    logic slot, ready, go, line_end, load;

    always_comb begin
        start_ok = en && (line_size != '0) && (line_count != '0);
        last_x   = (x == ls_s - DIM_WIDTH'(1));
        last_y   = (y == lc_s - DIM_WIDTH'(1));
        hb_last  = (blank_cnt == hb_s - DIM_WIDTH'(1));
        vb_last  = (vb_s == '0) || (blank_cnt == vb_s - DIM_WIDTH'(1));
        slot     = (st == ST_ACTIVE) && (sparse_cnt == '0) && !eol_pend;
`ifdef VIDEO_STREAM_GEN_READY_EN
        ready    = vid.rdy;
`else
        ready    = 1'b1;
`endif
        go       = slot && ready;
        // The idle gap after a line's last pixel is spent in ACTIVE before any blanking starts.
        if (SPARSE == 0) line_end = go && last_x;
        else             line_end = (st == ST_ACTIVE) && eol_pend && (sparse_cnt == SW'(1));
        load     = start_ok && ((st == ST_IDLE) || ((st == ST_VBLANK) && vb_last));
    end

    video_stream_pattern #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .DIM_WIDTH   (DIM_WIDTH)
    ) u_pattern (
        .x   (x),
        .y   (y),
        .sel (sel_s),
        .val (val_s),
        .pix (pix)
    );

    // Geometry and pattern are frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_s  <= '0;
            lc_s  <= '0;
            hb_s  <= '0;
            vb_s  <= '0;
            sel_s <= PAT_XRAMP;
            val_s <= '0;
        end else if (load) begin
            ls_s  <= line_size;
            lc_s  <= line_count;
            hb_s  <= hblank;
            vb_s  <= vblank;
            sel_s <= pattern_sel;
            val_s <= pattern_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            blank_cnt  <= '0;
            sparse_cnt <= '0;
            eol_pend   <= 1'b0;
            data_r     <= '0;
            de_r       <= 1'b0;
            hs_r       <= 1'b0;
            vs_r       <= 1'b0;
            fd_r       <= 1'b0;
        end else begin
            de_r <= 1'b0;
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            fd_r <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (load) begin
                        st         <= ST_ACTIVE;
                        x          <= '0;
                        y          <= '0;
                        blank_cnt  <= '0;
                        sparse_cnt <= '0;
                        eol_pend   <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (go) begin
                        data_r     <= pix;
                        de_r       <= 1'b1;
                        hs_r       <= (x == '0);
                        vs_r       <= (x == '0) && (y == '0);
                        sparse_cnt <= SPARSE_LD;
                        if (!last_x)          x        <= x + DIM_WIDTH'(1);
                        else if (SPARSE != 0) eol_pend <= 1'b1;
                    end else if (sparse_cnt != '0) begin
                        sparse_cnt <= sparse_cnt - SW'(1);
                    end
                    if (line_end) begin
                        eol_pend   <= 1'b0;
                        sparse_cnt <= '0;
                        x          <= '0;
                        blank_cnt  <= '0;
                        if (last_y)         st <= ST_VBLANK;
                        else if (hb_s == '0) y  <= y + DIM_WIDTH'(1);
                        else                st <= ST_HBLANK;
                    end
                end
                ST_HBLANK: begin
                    if (hb_last) begin
                        blank_cnt <= '0;
                        y         <= y + DIM_WIDTH'(1);
                        st        <= ST_ACTIVE;
                    end else begin
                        blank_cnt <= blank_cnt + DIM_WIDTH'(1);
                    end
                end
                ST_VBLANK: begin
                    fd_r <= (blank_cnt == '0);
                    if (vb_last) begin
                        blank_cnt  <= '0;
                        x          <= '0;
                        y          <= '0;
                        sparse_cnt <= '0;
                        st         <= load ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        blank_cnt <= blank_cnt + DIM_WIDTH'(1);
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign vid.data     = data_r;
    assign vid.de       = de_r;
    assign vid.hs       = hs_r;
    assign vid.vs       = vs_r;
    assign frame_done_o = fd_r;
    assign state_o      = st;

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen: one SPARSE=0 and one SPARSE=2 instance on shared inputs.
// The rdy stall sequence is only built when VIDEO_STREAM_GEN_READY_EN is defined.
module tb_video_stream_gen;
  import video_stream_pkg::*;

  localparam int PW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] line_size, line_count, hblank, vblank;
  logic [1:0]    pattern_sel;
  logic [PW-1:0] pattern_val;
  logic          fd0, fd2;
  vs_state_t     st0, st2;

  video_stream_gen_if #(.PIXEL_WIDTH(PW)) vid0 ();
  video_stream_gen_if #(.PIXEL_WIDTH(PW)) vid2 ();

  video_stream_gen #(.PIXEL_WIDTH(PW), .SPARSE(0), .DIM_WIDTH(DW)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .line_size(line_size), .line_count(line_count),
    .hblank(hblank), .vblank(vblank), .pattern_sel(pattern_sel), .pattern_val(pattern_val),
    .vid(vid0), .frame_done_o(fd0), .state_o(st0));

  video_stream_gen #(.PIXEL_WIDTH(PW), .SPARSE(2), .DIM_WIDTH(DW)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .line_size(line_size), .line_count(line_count),
    .hblank(hblank), .vblank(vblank), .pattern_sel(pattern_sel), .pattern_val(pattern_val),
    .vid(vid2), .frame_done_o(fd2), .state_o(st2));

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [PW-1:0] data;
    logic        hs;
    logic        vs;
  } px_t;

  typedef struct {
    int idx;
    int data;
    int hs;
    int vs;
    int gap;
  } vec_t;

  px_t           cap0[$], cap2[$];
  int            fdq0[$], fdq2[$];
  logic [PW-1:0] exp_q[$];
  int            cyc = 0;
  int            viol = 0;
  int            total = 0;
  int            bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // capture monitor, sampled 1 time unit after the active edge
  always begin
    @(posedge clk);
    #1;
    if (vid0.de === 1'b1) cap0.push_back(px_t'{cyc, vid0.data, vid0.hs, vid0.vs});
    if (vid2.de === 1'b1) cap2.push_back(px_t'{cyc, vid2.data, vid2.hs, vid2.vs});
    if (fd0 === 1'b1) fdq0.push_back(cyc);
    if (fd2 === 1'b1) fdq2.push_back(cyc);
    if ((vid0.hs === 1'b1 && vid0.de !== 1'b1) || (vid0.vs === 1'b1 && vid0.hs !== 1'b1)) viol++;
    if ((vid2.hs === 1'b1 && vid2.de !== 1'b1) || (vid2.vs === 1'b1 && vid2.hs !== 1'b1)) viol++;
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_and_start(input int ls, input int lc, input int hb, input int vb,
                                 input int sel, input int val);
    cyc_wait(1);
    rst_n       = 1'b0;
    line_size   = DW'(ls);
    line_count  = DW'(lc);
    hblank      = DW'(hb);
    vblank      = DW'(vb);
    pattern_sel = 2'(sel);
    pattern_val = PW'(val);
    en          = 1'b1;
    cyc_wait(2);
    cap0.delete(); cap2.delete(); fdq0.delete(); fdq2.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_cap(input int which, input int n, input int budget, input string name);
    int k;
    int sz;
    k  = 0;
    sz = (which == 0) ? cap0.size() : cap2.size();
    while (sz < n && k < budget) begin
      cyc_wait(1);
      k++;
      sz = (which == 0) ? cap0.size() : cap2.size();
    end
    total++;
    if (sz < n) begin
      bad++;
      $display("FAIL %s: got %0d pixels expected at least %0d within %0d cycles", name, sz, n, budget);
    end
  endtask

  task automatic wait_idle(input int which, input int budget, input string name);
    int k;
    k = 0;
    while (((which == 0) ? st0 : st2) != ST_IDLE && k < budget) begin
      cyc_wait(1);
      k++;
    end
    chk(name, 32'(((which == 0) ? st0 : st2)), 32'(ST_IDLE));
  endtask

  task automatic chk_vec0(input string name, input vec_t v);
    if (v.idx >= cap0.size()) begin
      chk({name, "_idx"}, 32'(cap0.size()), 32'(v.idx + 1));
    end else begin
      chk({name, "_data"}, 32'(cap0[v.idx].data), 32'(v.data));
      if (v.hs >= 0) chk({name, "_hs"}, 32'(cap0[v.idx].hs), 32'(v.hs));
      if (v.vs >= 0) chk({name, "_vs"}, 32'(cap0[v.idx].vs), 32'(v.vs));
      if (v.gap >= 0) chk({name, "_gap"}, 32'(cap0[v.idx].cyc - cap0[v.idx - 1].cyc), 32'(v.gap));
    end
  endtask

  vec_t t1[$];
  vec_t t3[$];
  vec_t t5[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // vector tables: {idx, data, hs, vs, gap}; -1 skips a field
    t1 = '{'{0, 0, 1, 1, -1}, '{1, 1, 0, 0, 1}, '{3, 3, 0, 0, 1}, '{4, 0, 1, 0, 3},
           '{8, 0, 1, 0, 3}, '{11, 3, 0, 0, 1}, '{12, 0, 1, 1, 6}, '{16, 0, 1, 0, 3}};
    t3 = '{'{11, 3, 0, 0, 1}, '{12, 0, 1, 1, 6}, '{15, 3, 0, 0, 1}, '{16, 4, 0, 0, 1},
           '{19, 7, 0, 0, 1}, '{20, 0, 1, 0, 3}, '{35, 7, 0, 0, 1}};
    t5 = '{'{0, 0, 1, 1, -1}, '{8, 'hFFF, 0, 0, 1}, '{15, 'hFFF, -1, -1, -1},
           '{16, 0, -1, -1, -1}, '{24, 'hFFF, -1, -1, -1}, '{32, 0, 1, 0, 1},
           '{231, 0, -1, -1, -1}, '{256, 'hFFF, 1, 0, -1}, '{264, 0, -1, -1, -1},
           '{480, 'hFFF, -1, -1, -1}, '{488, 0, -1, -1, -1}};

    rst_n = 1'b1;
    en = 1'b0;
    line_size = '0; line_count = '0; hblank = '0; vblank = '0;
    pattern_sel = PAT_XRAMP; pattern_val = '0;
`ifdef VIDEO_STREAM_GEN_READY_EN
    vid0.rdy = 1'b1;
    vid2.rdy = 1'b1;
`endif
    #1 rst_n = 1'b0;
    cyc_wait(3);
    chk("rst_de", 32'(vid0.de), 0);
    chk("rst_data", 32'(vid0.data), 0);
    chk("rst_hs", 32'(vid0.hs), 0);
    chk("rst_vs", 32'(vid0.vs), 0);
    chk("rst_fd", 32'(fd0), 0);
    chk("rst_state", 32'(st0), 32'(ST_IDLE));

    // 4x3 x ramp, two frames back to back
    reset_and_start(4, 3, 2, 5, PAT_XRAMP, 0);
    cyc_wait(30);
    en = 1'b0;
    wait_idle(0, 200, "t1_idle");
    chk("t1_count", 32'(cap0.size()), 24);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 12; i++) exp_q.push_back(PW'(i % 4));
    for (int i = 0; i < cap0.size(); i++) begin
      if (exp_q.size() == 0) break;
      chk("t1_sb_data", 32'(cap0[i].data), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    for (int i = 0; i < t1.size(); i++) chk_vec0("t1", t1[i]);
    chk("t1_fd_count", 32'(fdq0.size()), 2);
    if (fdq0.size() > 0 && cap0.size() > 11)
      chk("t1_fd_align", 32'(fdq0[0] - cap0[11].cyc), 1);

    // en dropped on the second pixel of line 1
    reset_and_start(4, 3, 2, 5, PAT_XRAMP, 0);
    wait_cap(0, 6, 100, "t2_wait");
    en = 1'b0;
    wait_idle(0, 200, "t2_idle");
    chk("t2_count", 32'(cap0.size()), 12);
    chk("t2_fd_count", 32'(fdq0.size()), 1);
    cyc_wait(20);
    chk("t2_no_more_de", 32'(cap0.size()), 12);

    // line_size raised mid-frame
    reset_and_start(4, 3, 2, 5, PAT_XRAMP, 0);
    wait_cap(0, 1, 50, "t3_first");
    line_size = DW'(8);
    wait_cap(0, 14, 200, "t3_second");
    en = 1'b0;
    wait_idle(0, 300, "t3_idle");
    chk("t3_count", 32'(cap0.size()), 36);
    for (int i = 0; i < t3.size(); i++) chk_vec0("t3", t3[i]);

    // asynchronous reset mid-line, constant pattern
    reset_and_start(4, 3, 2, 5, PAT_CONST, 'hABC);
    wait_cap(0, 2, 50, "t4_wait");
    chk("t4_pre_de", 32'(vid0.de), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_async_de", 32'(vid0.de), 0);
    chk("t4_async_data", 32'(vid0.data), 0);
    chk("t4_async_hs", 32'(vid0.hs), 0);
    chk("t4_async_state", 32'(st0), 32'(ST_IDLE));
    cyc_wait(2);
    cap0.delete();
    rst_n = 1'b1;
    wait_cap(0, 1, 50, "t4_restart");
    if (cap0.size() > 0) begin
      chk("t4_vs", 32'(cap0[0].vs), 1);
      chk("t4_hs", 32'(cap0[0].hs), 1);
      chk("t4_data", 32'(cap0[0].data), 'hABC);
    end
    en = 1'b0;
    wait_idle(0, 200, "t4_idle");

    // checker 32x16, no blanking
    reset_and_start(32, 16, 0, 0, PAT_CHECK, 0);
    wait_cap(0, 1, 50, "t5_first");
    en = 1'b0;
    wait_idle(0, 1500, "t5_idle");
    chk("t5_count", 32'(cap0.size()), 512);
    for (int i = 0; i < t5.size(); i++) chk_vec0("t5", t5[i]);
    chk("t5_fd_count", 32'(fdq0.size()), 1);

    // y ramp 3x4, one-cycle blanks
    reset_and_start(3, 4, 1, 1, PAT_YRAMP, 0);
    wait_cap(0, 1, 50, "t6_first");
    en = 1'b0;
    wait_idle(0, 200, "t6_idle");
    chk("t6_count", 32'(cap0.size()), 12);
    chk_vec0("t6_a", '{3, 1, 1, 0, 2});
    chk_vec0("t6_b", '{7, 2, 0, 0, 1});
    chk_vec0("t6_c", '{11, 3, 0, 0, 1});

    // single-pixel lines: every pixel is a line start
    reset_and_start(1, 3, 1, 1, PAT_YRAMP, 0);
    wait_cap(0, 1, 50, "t7_first");
    en = 1'b0;
    wait_idle(0, 100, "t7_idle");
    chk("t7_count", 32'(cap0.size()), 3);
    chk_vec0("t7_a", '{1, 1, 1, 0, 2});
    chk_vec0("t7_b", '{2, 2, 1, 0, 2});

    // SPARSE=2 instance, 5-pixel lines
    reset_and_start(5, 2, 2, 3, PAT_XRAMP, 0);
    wait_cap(2, 1, 50, "t8_first");
    en = 1'b0;
    wait_idle(2, 300, "t8_idle");
    chk("t8_count", 32'(cap2.size()), 10);
    if (cap2.size() >= 10) begin
      for (int i = 1; i < 5; i++) chk("t8_gap", 32'(cap2[i].cyc - cap2[i - 1].cyc), 3);
      chk("t8_span", 32'(cap2[4].cyc - cap2[0].cyc), 12);
      chk("t8_line_gap", 32'(cap2[5].cyc - cap2[4].cyc), 5);
      chk("t8_hs", 32'(cap2[5].hs), 1);
      chk("t8_data", 32'(cap2[6].data), 1);
    end
    chk("t8_fd_count", 32'(fdq2.size()), 1);

`ifdef VIDEO_STREAM_GEN_READY_EN
    // rdy low for 3 cycles at x=2
    reset_and_start(4, 1, 2, 2, PAT_XRAMP, 0);
    wait_cap(0, 2, 50, "t9_wait");
    vid0.rdy = 1'b0;
    vid2.rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vid0.rdy = 1'b1;
    vid2.rdy = 1'b1;
    en = 1'b0;
    wait_idle(0, 100, "t9_idle");
    chk("t9_count", 32'(cap0.size()), 4);
    chk_vec0("t9_a", '{2, 2, 0, 0, 4});
    chk_vec0("t9_b", '{3, 3, 0, 0, 1});
`endif

    chk("strobe_qual", 32'(viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
